mic_adc_capture: RTL and testbench

Serial-ADC front end for the microphone path: the responder side of the processor's `mic_start` / `mic_done` / `mic_data` handshake. A rising edge on `mic_start` triggers one 16-clock SPI-style read of a 12-bit ADC (4 leading zeros, then 12 data bits MSB-first). On completion it presents the sample on `mic_data` and raises `mic_done`, which the processor polls through the memory-mapped IO space. It sits between the IO controller and the board ADC pins, in the `clk` domain.

---
 rtl/mic_adc_capture.sv | 144 ++++++++++++++
 tb/tb_mic_adc_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_adc_capture.sv
// mic_adc_capture
//   Responder side of the processor mic_start/mic_done/mic_data handshake.
//   A rising edge on mic_start runs one 16-clock SPI-style read of a 12-bit
//   serial ADC (4 leading zeros, then 12 data bits MSB-first), waits a quiet
//   gap with chip select high, then presents the sample and raises mic_done.
//
// Parameters
//   CLK_DIV    clk cycles per SCLK half-period (>=1)
//   QUIET_CYC  clk cycles with adc_cs_n high after a frame before mic_done (>=1)
//
// Ports
//   clk        system clock, posedge
//   reset      synchronous, active-high
//   mic_start  conversion request, acted on at its 0->1 transition only
//   mic_done   sample valid, high from completion until the next accepted start
//   mic_data   last completed 12-bit sample
//   mic_busy   high while a frame or its quiet gap is in progress
//   adc_sdata  ADC serial data, changes after SCLK falling edge
//   adc_sclk   ADC serial clock, idles high
//   adc_cs_n   ADC chip select, active-low, idles high
module mic_adc_capture #(
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mic_start,
    output logic        mic_done,
    output logic [11:0] mic_data,
    output logic        mic_busy,
    input  logic        adc_sdata,
    output logic        adc_sclk,
    output logic        adc_cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int Q_W   = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        QUIET
    } state_t;

    state_t state;
    state_t next_state;

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [Q_W-1:0]   quiet_cnt;
    // Only the 12 data bits are retained; the four leading zero bits shift
    // out of the top and are discarded without being checked.
    logic [11:0]      shift;
    logic             start_q;

    logic start_edge;
    logic div_wrap;
    logic sample;
    logic last_sample;
    logic quiet_last;

    always_comb begin
        start_edge  = mic_start & ~start_q;
        div_wrap    = (div_cnt == DIV_LAST);
        // A wrap while SCLK is low is the rising edge: the ADC data is stable.
        sample      = div_wrap & ~adc_sclk;
        last_sample = sample & (bit_cnt == 5'd15);
        quiet_last  = (quiet_cnt == Q_LAST);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge)  next_state = CONV;
            CONV:    if (last_sample) next_state = QUIET;
            QUIET:   if (quiet_last)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q   <= 1'b1;
            mic_done  <= 1'b0;
            mic_data  <= '0;
            mic_busy  <= 1'b0;
            adc_sclk  <= 1'b1;
            adc_cs_n  <= 1'b1;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            shift     <= '0;
        end else begin
            start_q <= mic_start;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        adc_cs_n <= 1'b0;
                        mic_done <= 1'b0;
                        mic_busy <= 1'b1;
                        adc_sclk <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        shift    <= '0;
                    end
                end
                CONV: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        adc_sclk <= ~adc_sclk;
                        if (sample) begin
                            shift   <= {shift[10:0], adc_sdata};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (last_sample) begin
                                adc_cs_n  <= 1'b1;
                                quiet_cnt <= '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                QUIET: begin
                    if (quiet_last) begin
                        mic_data <= shift;
                        mic_done <= 1'b1;
                        mic_busy <= 1'b0;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mic_adc_capture.sv
// tb_mic_adc_capture
//   Directed bench for mic_adc_capture. One instance with default timing
//   and one with CLK_DIV=1, QUIET_CYC=1 for back-to-back frames. Each has a
//   behavioural ADC that loads a 16-bit word at chip-select fall and drives
//   the next bit MSB-first after every SCLK falling edge.
module tb_mic_adc_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        mic_start;
    logic        mic_done;
    logic [11:0] mic_data;
    logic        mic_busy;
    logic        adc_sdata = 1'b0;
    logic        adc_sclk;
    logic        adc_cs_n;

    logic        reset_f;
    logic        start_f;
    logic        done_f;
    logic [11:0] data_f;
    logic        busy_f;
    logic        sdata_f = 1'b0;
    logic        sclk_f;
    logic        cs_n_f;

    logic [15:0] word;
    logic [15:0] word_f;
    logic [15:0] cur;
    logic [15:0] cur_f;
    int          idx;
    int          idx_f;
    int          frame_cnt = 0;
    int          fall_cnt  = 0;
    int          low_cnt   = 0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mic_adc_capture #(.CLK_DIV(4), .QUIET_CYC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mic_start (mic_start),
        .mic_done  (mic_done),
        .mic_data  (mic_data),
        .mic_busy  (mic_busy),
        .adc_sdata (adc_sdata),
        .adc_sclk  (adc_sclk),
        .adc_cs_n  (adc_cs_n)
    );

    mic_adc_capture #(.CLK_DIV(1), .QUIET_CYC(1)) dut_fast (
        .clk       (clk),
        .reset     (reset_f),
        .mic_start (start_f),
        .mic_done  (done_f),
        .mic_data  (data_f),
        .mic_busy  (busy_f),
        .adc_sdata (sdata_f),
        .adc_sclk  (sclk_f),
        .adc_cs_n  (cs_n_f)
    );

    // ADC models: chip-select fall happens with SCLK idle high, an SCLK fall
    // happens with SCLK low, which tells the two events apart.
    always @(negedge adc_cs_n or negedge adc_sclk) begin
        if (!adc_cs_n) begin
            if (adc_sclk) begin
                cur = word;
                idx = 0;
                frame_cnt++;
            end else begin
                if (idx < 16) adc_sdata = cur[15-idx];
                idx++;
                fall_cnt++;
            end
        end
    end

    always @(negedge cs_n_f or negedge sclk_f) begin
        if (!cs_n_f) begin
            if (sclk_f) begin
                cur_f = word_f;
                idx_f = 0;
            end else begin
                if (idx_f < 16) sdata_f = cur_f[15-idx_f];
                idx_f++;
            end
        end
    end

    always @(posedge clk) if (!adc_cs_n) low_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges after E0 at which done was seen, or -1.
    task automatic wait_done(input bit fast, output int n);
        n = -1;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if ((fast ? done_f : mic_done) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int f0;
    int l0;
    int fr0;

    initial begin
        reset     = 1'b1;
        mic_start = 1'b1;
        reset_f   = 1'b1;
        start_f   = 1'b0;
        word      = '0;
        word_f    = '0;
        repeat (3) tick();
        reset   = 1'b0;
        reset_f = 1'b0;
        tick();
        check("rst_done", mic_done, 0);
        check("rst_data", mic_data, 0);
        check("rst_busy", mic_busy, 0);
        check("rst_sclk", adc_sclk, 1);
        check("rst_cs_n", adc_cs_n, 1);
        repeat (5) tick();
        check("held_start_no_frame", adc_cs_n, 1);
        mic_start = 1'b0;
        tick();

        // Single frame, sample 0xABC
        word = 16'h0ABC;
        f0 = fall_cnt;
        l0 = low_cnt;
        mic_start = 1'b1;
        tick();
        mic_start = 1'b0;
        check("e0_cs_n", adc_cs_n, 0);
        check("e0_busy", mic_busy, 1);
        wait_done(1'b0, n);
        check("t1_done_lat", n, 136);
        check("t1_data", mic_data, 12'hABC);
        check("t1_sclk_falls", fall_cnt - f0, 16);
        check("t1_cs_low", low_cnt - l0, 128);
        check("t1_busy", mic_busy, 0);

        // Start held for 1000 cycles
        word = 16'h0555;
        fr0 = frame_cnt;
        mic_start = 1'b1;
        repeat (500) tick();
        check("t2_data_mid", mic_data, 12'h555);
        repeat (500) tick();
        check("t2_frames", frame_cnt - fr0, 1);
        check("t2_done", mic_done, 1);
        check("t2_data_end", mic_data, 12'h555);
        mic_start = 1'b0;
        tick();

        // Restart with done high and data 0x555
        word = 16'h0A5A;
        mic_start = 1'b1;
        tick();
        mic_start = 1'b0;
        check("t6_done_clr", mic_done, 0);
        check("t6_data_hold", mic_data, 12'h555);
        repeat (99) tick();
        check("t6_data_mid", mic_data, 12'h555);
        wait_done(1'b0, n);
        check("t6_done_lat", n, 37);
        check("t6_data", mic_data, 12'hA5A);

        // Second start edge at E0+40 is ignored
        word = 16'h0C3C;
        fr0 = frame_cnt;
        mic_start = 1'b1;
        tick();
        mic_start = 1'b0;
        repeat (39) tick();
        mic_start = 1'b1;
        tick();
        mic_start = 1'b0;
        check("t3_busy", mic_busy, 1);
        wait_done(1'b0, n);
        check("t3_done_lat", n, 96);
        check("t3_data", mic_data, 12'hC3C);
        repeat (200) tick();
        check("t3_frames", frame_cnt - fr0, 1);
        check("t3_done_stays", mic_done, 1);

        // Reset at E0+60
        word = 16'h0777;
        mic_start = 1'b1;
        tick();
        mic_start = 1'b0;
        repeat (59) tick();
        reset = 1'b1;
        tick();
        check("t4_cs_n", adc_cs_n, 1);
        check("t4_sclk", adc_sclk, 1);
        check("t4_done", mic_done, 0);
        check("t4_data", mic_data, 0);
        check("t4_busy", mic_busy, 0);
        reset = 1'b0;
        tick();
        word = 16'h0123;
        mic_start = 1'b1;
        tick();
        mic_start = 1'b0;
        wait_done(1'b0, n);
        check("t4_done_lat", n, 136);
        check("t4_data_new", mic_data, 12'h123);

        // Back-to-back on the fast instance
        word_f = 16'h0FFF;
        start_f = 1'b1;
        tick();
        start_f = 1'b0;
        wait_done(1'b1, n);
        check("t5a_done_lat", n, 33);
        check("t5a_data", data_f, 12'hFFF);
        word_f = 16'h0001;
        start_f = 1'b1;
        tick();
        start_f = 1'b0;
        check("t5b_done_clr", done_f, 0);
        check("t5b_data_hold", data_f, 12'hFFF);
        wait_done(1'b1, n);
        check("t5b_done_lat", n, 33);
        check("t5b_data", data_f, 12'h001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
